// File: rtl/ring_lock_ctrl.sv
// ring_lock_ctrl: wavelength-lock controller for one microring channel.
// It sweeps the heater code across a window, parks on the drop-port power peak,
// then dithers around that code to follow thermal drift. A large power loss
// starts a new sweep.
//
// Sample stream: pd_valid/pd_code is valid-only, with no ready signal. A sample is
// consumed only in the cycle where a measure state (MEAS, VERIFY, TRK_C, TRK_P,
// TRK_M) sees pd_valid=1. Samples that arrive in any other state are dropped.
module ring_lock_ctrl #(
    parameter int CODE_W      = 8,
    parameter int PWR_W       = 10,
    parameter int SETTLE_CYC  = 2,
    parameter int MIN_PWR     = 64,
    parameter int LOCK_THRESH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [CODE_W-1:0] sweep_lo,
    input  logic [CODE_W-1:0] sweep_hi,
    input  logic              pd_valid,
    input  logic [PWR_W-1:0]  pd_code,
    output logic [CODE_W-1:0] heater_code,
    output logic              busy,
    output logic              locked,
    output logic [CODE_W-1:0] lock_code,
    output logic [PWR_W-1:0]  ref_pwr,
    output logic              err,
    output logic [3:0]        relock_cnt,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        MEAS   = 3'd2,
        VERIFY = 3'd3,
        TRK_C  = 3'd4,
        TRK_P  = 3'd5,
        TRK_M  = 3'd6
    } state_t;

    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
    localparam logic [PWR_W-1:0] MIN_P = PWR_W'(MIN_PWR);
    localparam logic [PWR_W-1:0] THR   = PWR_W'(LOCK_THRESH);

    state_t            state_q, state_d, pend_q, pend_d, nxt_meas;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CODE_W-1:0] lo_q, lo_d, hi_q, hi_d;
    logic [CODE_W-1:0] heater_q, heater_d, best_code_q, best_code_d, lock_code_q, lock_code_d;
    logic [PWR_W-1:0]  best_q, best_d, p0_q, p0_d, ref_q, ref_d;
    logic              locked_q, locked_d, err_q, err_d;
    logic [3:0]        relock_q, relock_d;
    logic              settle_go;

    // Next-state and datapath updates; every heater move routes through SETTLE.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        cnt_d       = cnt_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        heater_d    = heater_q;
        best_d      = best_q;
        best_code_d = best_code_q;
        lock_code_d = lock_code_q;
        p0_d        = p0_q;
        ref_d       = ref_q;
        locked_d    = locked_q;
        err_d       = err_q;
        relock_d    = relock_q;
        settle_go   = 1'b0;
        nxt_meas    = MEAS;

        if (stop) begin
            state_d  = IDLE;
            locked_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (sweep_lo > sweep_hi) begin
                            err_d = 1'b1;
                        end else begin
                            err_d       = 1'b0;
                            relock_d    = 4'd0;
                            lo_d        = sweep_lo;
                            hi_d        = sweep_hi;
                            best_d      = '0;
                            best_code_d = sweep_lo;
                            heater_d    = sweep_lo;
                            settle_go   = 1'b1;
                            nxt_meas    = MEAS;
                        end
                    end
                end
                SETTLE: begin
                    if (cnt_q == CNT_LAST) state_d = pend_q;
                    else                   cnt_d   = cnt_q + 1'b1;
                end
                MEAS: begin
                    if (pd_valid) begin
                        // Strictly greater: on a tie the lower (earlier) code wins.
                        if (pd_code > best_q) begin
                            best_d      = pd_code;
                            best_code_d = heater_q;
                        end
                        if (heater_q == hi_q) begin
                            heater_d = (pd_code > best_q) ? heater_q : best_code_q;
                            nxt_meas = VERIFY;
                        end else begin
                            heater_d = heater_q + 1'b1;
                            nxt_meas = MEAS;
                        end
                        settle_go = 1'b1;
                    end
                end
                VERIFY: begin
                    if (pd_valid) begin
                        if (pd_code < MIN_P) begin
                            err_d    = 1'b1;
                            heater_d = lo_q;
                            state_d  = IDLE;
                        end else begin
                            ref_d       = pd_code;
                            lock_code_d = heater_q;
                            locked_d    = 1'b1;
                            settle_go   = 1'b1;
                            nxt_meas    = TRK_C;
                        end
                    end
                end
                TRK_C: begin
                    if (pd_valid) begin
                        if (ref_q >= THR && pd_code < ref_q - THR) begin
                            locked_d    = 1'b0;
                            relock_d    = (relock_q == 4'hf) ? relock_q : relock_q + 4'd1;
                            best_d      = '0;
                            best_code_d = lo_q;
                            heater_d    = lo_q;
                            settle_go   = 1'b1;
                            nxt_meas    = MEAS;
                        end else begin
                            p0_d = pd_code;
                            if (lock_code_q < hi_q) begin
                                heater_d  = lock_code_q + 1'b1;
                                settle_go = 1'b1;
                                nxt_meas  = TRK_P;
                            end else if (lock_code_q > lo_q) begin
                                heater_d  = lock_code_q - 1'b1;
                                settle_go = 1'b1;
                                nxt_meas  = TRK_M;
                            end
                            // A single-point window has nowhere to probe; stay centered.
                        end
                    end
                end
                TRK_P: begin
                    if (pd_valid) begin
                        settle_go = 1'b1;
                        if (pd_code > p0_q) begin
                            lock_code_d = heater_q;
                            nxt_meas    = TRK_C;
                        end else if (lock_code_q > lo_q) begin
                            heater_d = lock_code_q - 1'b1;
                            nxt_meas = TRK_M;
                        end else begin
                            heater_d = lock_code_q;
                            nxt_meas = TRK_C;
                        end
                    end
                end
                TRK_M: begin
                    if (pd_valid) begin
                        settle_go = 1'b1;
                        nxt_meas  = TRK_C;
                        if (pd_code > p0_q) lock_code_d = heater_q;
                        else                heater_d    = lock_code_q;
                    end
                end
                default: state_d = IDLE;
            endcase

            // With zero settle cycles the pending measure state is entered directly.
            if (settle_go) begin
                if (SETTLE_CYC == 0) begin
                    state_d = nxt_meas;
                end else begin
                    state_d = SETTLE;
                    pend_d  = nxt_meas;
                    cnt_d   = '0;
                end
            end
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pend_q      <= MEAS;
            cnt_q       <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
            heater_q    <= '0;
            best_q      <= '0;
            best_code_q <= '0;
            lock_code_q <= '0;
            p0_q        <= '0;
            ref_q       <= '0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            relock_q    <= 4'd0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            cnt_q       <= cnt_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            heater_q    <= heater_d;
            best_q      <= best_d;
            best_code_q <= best_code_d;
            lock_code_q <= lock_code_d;
            p0_q        <= p0_d;
            ref_q       <= ref_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
            relock_q    <= relock_d;
        end
    end

    assign heater_code = heater_q;
    assign busy        = (state_q != IDLE);
    assign locked      = locked_q;
    assign lock_code   = lock_code_q;
    assign ref_pwr     = ref_q;
    assign err         = err_q;
    assign relock_cnt  = relock_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_ring_lock_ctrl.sv
// Bench for ring_lock_ctrl: a table of lock scenarios plus hand-written sequences
// for drift, relock, no-peak, window errors, stop, pd gaps and reset.
module tb_ring_lock_ctrl;

    localparam int SB_W = 16;

    logic       clk = 1'b0;
    logic       rst, start, stop, pd_valid;
    logic [7:0] sweep_lo, sweep_hi;
    logic [9:0] pd_code;
    logic [7:0] heater_code, lock_code;
    logic       busy, locked, err;
    logic [9:0] ref_pwr;
    logic [3:0] relock_cnt;
    logic [2:0] state_dbg;

    int peak_p;
    int model_mode;
    int n_checks;
    int n_fail;

    logic [SB_W-1:0] exp_q[$];

    typedef struct {
        int mode;
        int peak;
        int lo;
        int hi;
        int exp_code;
        int exp_ref;
        int exp_cyc;
    } vec_t;

    vec_t vecs[6];

    ring_lock_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .sweep_lo(sweep_lo), .sweep_hi(sweep_hi),
        .pd_valid(pd_valid), .pd_code(pd_code),
        .heater_code(heater_code), .busy(busy), .locked(locked),
        .lock_code(lock_code), .ref_pwr(ref_pwr), .err(err),
        .relock_cnt(relock_cnt), .state_dbg(state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    // Ring power model: 0 = triangular peak at peak_p, 1 = equal peaks at 36 and 38, 2 = flat 20
    function automatic logic [9:0] pd_model(input logic [7:0] code, input int p, input int m);
        int d;
        int v;
        d = int'(code) - p;
        if (d < 0) d = -d;
        case (m)
            1:       v = (code == 8'd36 || code == 8'd38) ? 500 : 400 - 10 * d;
            2:       v = 20;
            default: v = 500 - 10 * d;
        endcase
        if (v < 0) v = 0;
        return v[9:0];
    endfunction

    assign pd_code = pd_model(heater_code, peak_p, model_mode);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pulse start for one cycle; on return the bench is in cycle 1.
    task automatic start_sweep(input int lo, input int hi);
        sweep_lo = lo[7:0];
        sweep_hi = hi[7:0];
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Tick until locked rises; c counts cycles, beginning at c0 on entry.
    task automatic wait_lock(input int c0, output int c);
        c = c0;
        while (!locked && c < 2000) begin
            tick();
            c++;
        end
        if (!locked) chk("lock_timeout", 32'(locked), 32'd1);
    endtask

    task automatic abort();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
    endtask

    task automatic sb_expect(input int code, input int refp, input int e, input int rc);
        exp_q.push_back(SB_W'(code));
        exp_q.push_back(SB_W'(refp));
        exp_q.push_back(SB_W'(e));
        exp_q.push_back(SB_W'(rc));
    endtask

    task automatic sb_compare();
        logic [SB_W-1:0] e;
        if (exp_q.size() < 4) begin
            chk("sb_underflow", 32'(exp_q.size()), 32'd4);
        end else begin
            e = exp_q.pop_front(); chk("lock_code", 32'(lock_code), 32'(e));
            e = exp_q.pop_front(); chk("ref_pwr", 32'(ref_pwr), 32'(e));
            e = exp_q.pop_front(); chk("err", 32'(err), 32'(e));
            e = exp_q.pop_front(); chk("relock_cnt", 32'(relock_cnt), 32'(e));
        end
    endtask

    initial begin
        int c;
        int drops;
        int hmin;
        int hmax;
        logic [7:0] h;

        vecs[0] = '{mode: 0, peak: 37,  lo: 30, hi: 45,  exp_code: 37,  exp_ref: 500, exp_cyc: 52};
        vecs[1] = '{mode: 0, peak: 37,  lo: 37, hi: 37,  exp_code: 37,  exp_ref: 500, exp_cyc: 7};
        vecs[2] = '{mode: 1, peak: 37,  lo: 30, hi: 45,  exp_code: 36,  exp_ref: 500, exp_cyc: 52};
        vecs[3] = '{mode: 0, peak: 20,  lo: 30, hi: 45,  exp_code: 30,  exp_ref: 400, exp_cyc: 52};
        vecs[4] = '{mode: 0, peak: 100, lo: 0,  hi: 255, exp_code: 100, exp_ref: 500, exp_cyc: 772};
        vecs[5] = '{mode: 0, peak: 50,  lo: 10, hi: 13,  exp_code: 13,  exp_ref: 130, exp_cyc: 16};

        n_checks   = 0;
        n_fail     = 0;
        peak_p     = 37;
        model_mode = 0;
        rst        = 1'b1;
        start      = 1'b0;
        stop       = 1'b0;
        pd_valid   = 1'b1;
        sweep_lo   = 8'd0;
        sweep_hi   = 8'd0;

        // Reset state
        tick();
        tick();
        chk("rst_heater", 32'(heater_code), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'd0);
        rst = 1'b0;
        tick();

        // Table-driven lock scenarios
        for (int i = 0; i < 6; i++) begin
            model_mode = vecs[i].mode;
            peak_p     = vecs[i].peak;
            sb_expect(vecs[i].exp_code, vecs[i].exp_ref, 0, 0);
            start_sweep(vecs[i].lo, vecs[i].hi);
            chk("first_heater", 32'(heater_code), 32'(vecs[i].lo));
            chk("first_busy", 32'(busy), 32'd1);
            wait_lock(1, c);
            chk("lock_cycle", 32'(c), 32'(vecs[i].exp_cyc));
            sb_compare();
            abort();
        end

        // Drift tracking: peak moves 37 -> 38 after lock
        model_mode = 0;
        peak_p     = 37;
        sb_expect(37, 500, 0, 0);
        start_sweep(30, 45);
        wait_lock(1, c);
        sb_compare();
        peak_p = 38;
        drops  = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (!locked) drops++;
        end
        chk("drift_lock_held", 32'(drops), 32'd0);
        chk("drift_lock_code", 32'(lock_code), 32'd38);
        hmin = 255;
        hmax = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (int'(heater_code) < hmin) hmin = int'(heater_code);
            if (int'(heater_code) > hmax) hmax = int'(heater_code);
            if (!locked) drops++;
        end
        chk("dither_min", 32'(hmin), 32'd37);
        chk("dither_max", 32'(hmax), 32'd39);
        chk("dither_lock_held", 32'(drops), 32'd0);
        chk("dither_lock_code", 32'(lock_code), 32'd38);
        chk("dither_relock_cnt", 32'(relock_cnt), 32'd0);
        abort();

        // Relock: peak jumps to 60, re-sweep parks on the window edge
        peak_p = 37;
        start_sweep(30, 45);
        wait_lock(1, c);
        peak_p = 60;
        c = 0;
        while (locked && c < 50) begin
            tick();
            c++;
        end
        chk("relock_fall", 32'(locked), 32'd0);
        chk("relock_fall_cycle", 32'(c), 32'd3);
        chk("relock_busy", 32'(busy), 32'd1);
        chk("relock_heater", 32'(heater_code), 32'd30);
        sb_expect(45, 350, 0, 1);
        wait_lock(1, c);
        chk("relock_cycle", 32'(c), 32'd52);
        sb_compare();
        abort();

        // No peak: VERIFY fails, err set, heater parked at sweep_lo
        model_mode = 2;
        start_sweep(30, 45);
        c = 1;
        while (busy && c < 200) begin
            tick();
            c++;
        end
        chk("nopeak_idle_cycle", 32'(c), 32'd52);
        chk("nopeak_err", 32'(err), 32'd1);
        chk("nopeak_busy", 32'(busy), 32'd0);
        chk("nopeak_locked", 32'(locked), 32'd0);
        chk("nopeak_heater", 32'(heater_code), 32'd30);
        model_mode = 0;
        peak_p     = 37;
        start_sweep(30, 45);
        chk("restart_err_clr", 32'(err), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);
        abort();

        // Inverted window
        start_sweep(50, 40);
        chk("badwin_err", 32'(err), 32'd1);
        chk("badwin_busy", 32'(busy), 32'd0);
        tick();
        chk("badwin_state", 32'(state_dbg), 32'd0);

        // start while busy is ignored
        start_sweep(30, 45);
        chk("busy_start_err_clr", 32'(err), 32'd0);
        for (int i = 0; i < 9; i++) tick();
        sweep_lo = 8'd0;
        sweep_hi = 8'd255;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        sweep_lo = 8'd30;
        sweep_hi = 8'd45;
        sb_expect(37, 500, 0, 0);
        wait_lock(11, c);
        chk("busy_start_cycle", 32'(c), 32'd52);
        sb_compare();
        abort();

        // stop mid-sweep holds the heater
        start_sweep(30, 45);
        for (int i = 0; i < 19; i++) tick();
        h    = heater_code;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_locked", 32'(locked), 32'd0);
        chk("stop_heater", 32'(heater_code), 32'(h));
        for (int i = 0; i < 5; i++) tick();
        chk("stop_heater_hold", 32'(heater_code), 32'(h));
        chk("stop_state", 32'(state_dbg), 32'd0);

        // pd_valid gap on the first measurement delays the lock by the gap length
        start_sweep(30, 45);
        tick();
        tick();
        pd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 2) chk("gap_busy", 32'(busy), 32'd1);
        end
        pd_valid = 1'b1;
        sb_expect(37, 500, 0, 0);
        wait_lock(8, c);
        chk("gap_lock_cycle", 32'(c), 32'd57);
        sb_compare();

        // rst while locked with start high in the same cycle
        rst      = 1'b1;
        start    = 1'b1;
        sweep_lo = 8'd30;
        sweep_hi = 8'd45;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        chk("rst2_heater", 32'(heater_code), 32'd0);
        chk("rst2_busy", 32'(busy), 32'd0);
        chk("rst2_locked", 32'(locked), 32'd0);
        chk("rst2_lock_code", 32'(lock_code), 32'd0);
        chk("rst2_ref_pwr", 32'(ref_pwr), 32'd0);
        chk("rst2_err", 32'(err), 32'd0);
        chk("rst2_relock", 32'(relock_cnt), 32'd0);
        tick();
        chk("rst2_idle", 32'(state_dbg), 32'd0);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
